// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, ACC source encodings, widths and state type for the accumulator CPU
package cpu_pkg;
  localparam int DATA_W_DEF = 4;
  localparam int PC_W_DEF = 4;
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_NOR = 4'b0011;
  localparam logic [3:0] OP_LDR = 4'b0100;
  localparam logic [3:0] OP_STR = 4'b0101;
  localparam logic [3:0] OP_JZR = 4'b0110;
  localparam logic [3:0] OP_JZI = 4'b0111;
  localparam logic [3:0] OP_JCR = 4'b1000;
  localparam logic [3:0] OP_JCI = 4'b1010;
  localparam logic [3:0] OP_SHL = 4'b1011;
  localparam logic [3:0] OP_SHR = 4'b1100;
  localparam logic [3:0] OP_LDI = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [1:0] ACC_IMM = 2'b00;
  localparam logic [1:0] ACC_ALU = 2'b01;
  localparam logic [1:0] ACC_REG = 2'b10;
  localparam logic [1:0] ACC_HOLD = 2'b11;
  typedef enum logic {FETCH0, RUN} state_t;
endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU, (i_a, i_b, i_sel) -> (o_res, o_carry); unknown codes pass i_a with carry 0
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [3:0]   i_sel,
  output logic [W-1:0] o_res,
  output logic         o_carry
);
  always_comb begin
    {o_carry, o_res} = {1'b0, i_a};
    case (i_sel)
      OP_ADD: {o_carry, o_res} = {1'b0, i_a} + {1'b0, i_b};
      OP_SUB: begin
        o_res = i_a - i_b;
        o_carry = i_b > i_a;
      end
      OP_NOR: o_res = ~(i_a | i_b);
      OP_SHR: {o_res, o_carry} = {1'b0, i_a};
      OP_SHL: {o_carry, o_res} = {i_a, 1'b0};
      default: ;
    endcase
  end
endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: PC, IR, ACC, carry, 16-entry register file and ALU of the accumulator CPU
//   in : CLK, CLB (async active-low reset), Instr (ROM word at PCAddr), controller strobes
//        LoadIR/IncPC/SelPC/LoadPC/LoadReg/LoadAcc, SelAcc (ACC source), SelALU (ALU op)
//   out: PCAddr (next PC, ROM address), Opcode (IR[7:4]), Z (ACC != 0), C (carry), Halted
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W = PC_W_DEF
) (
  input  logic              CLK,
  input  logic              CLB,
  input  logic [7:0]        Instr,
  input  logic              LoadIR,
  input  logic              IncPC,
  input  logic              SelPC,
  input  logic              LoadPC,
  input  logic              LoadReg,
  input  logic              LoadAcc,
  input  logic [1:0]        SelAcc,
  input  logic [3:0]        SelALU,
  output logic [PC_W-1:0]   PCAddr,
  output logic [3:0]        Opcode,
  output logic              Z,
  output logic              C,
  output logic              Halted
);
  state_t r_state;
  logic [PC_W-1:0] r_pc;
  logic [7:0] r_ir;
  logic [DATA_W-1:0] r_acc;
  logic r_c;
  logic [DATA_W-1:0] r_regs [16];
  logic w_run;
  logic [3:0] w_operand;
  logic [DATA_W-1:0] w_imm, w_r, w_alu_res, w_acc_d;
  logic w_alu_c;
  logic [PC_W-1:0] w_next_pc;
  assign w_run = r_state == RUN;
  assign w_operand = r_ir[3:0];
  assign w_imm = DATA_W'(w_operand);
  assign w_r = r_regs[w_operand];
  assign w_next_pc = LoadPC ? (SelPC ? PC_W'(w_imm) : PC_W'(w_r)) :
                     IncPC ? r_pc + PC_W'(1) : r_pc;
  // FETCH0 always fetches address 0, whatever the (possibly unknown) strobes say
  assign PCAddr = w_run ? w_next_pc : '0;
  assign Opcode = r_ir[7:4];
  assign Z = |r_acc;
  assign C = r_c;
  assign Halted = w_run && Opcode == OP_HALT;
  assign w_acc_d = SelAcc == ACC_IMM ? w_imm :
                   SelAcc == ACC_ALU ? w_alu_res :
                   SelAcc == ACC_REG ? w_r : r_acc;
  cpu_alu #(.W(DATA_W)) u_alu (
    .i_a(r_acc),
    .i_b(w_r),
    .i_sel(SelALU),
    .o_res(w_alu_res),
    .o_carry(w_alu_c)
  );
  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      r_state <= FETCH0;
      r_pc <= '0;
      r_ir <= '0;
      r_acc <= '0;
      r_c <= 1'b0;
    end else if (!w_run) begin
      r_state <= RUN;
      r_pc <= '0;
      r_ir <= Instr;
    end else begin
      r_pc <= w_next_pc;
      if (LoadIR) r_ir <= Instr;
      if (LoadAcc) r_acc <= w_acc_d;
      if (LoadAcc && SelAcc == ACC_ALU) r_c <= w_alu_c;
    end
  end
  // the register read above sees the pre-edge value even when it is written this edge
  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else if (w_run && LoadReg) begin
      r_regs[w_operand] <= r_acc;
    end
  end
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: scoreboard bench with a behavioural CPU model, directed program and random strobes
module tb_cpu_datapath;
  logic CLK = 1'b0;
  logic CLB = 1'b0;
  logic [7:0] Instr;
  logic LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
  logic [1:0] SelAcc;
  logic [3:0] SelALU;
  logic [3:0] PCAddr, Opcode;
  logic Z, C, Halted;
  logic [7:0] rom [16];
  typedef struct packed {
    logic [3:0] pa;
    logic [3:0] op;
    logic z;
    logic c;
    logic h;
  } exp_t;
  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit rnd_mode = 0;
  bit m_run;
  int m_pc, m_acc, m_c;
  logic [7:0] m_ir;
  int m_reg [16];
  always #5 CLK = ~CLK;
  assign Instr = rom[PCAddr];
  cpu_datapath dut (
    .CLK(CLK), .CLB(CLB), .Instr(Instr),
    .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
    .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU),
    .PCAddr(PCAddr), .Opcode(Opcode), .Z(Z), .C(C), .Halted(Halted)
  );
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  task automatic model_reset(output exp_t e);
    m_run = 0; m_pc = 0; m_ir = 8'h00; m_acc = 0; m_c = 0;
    for (int i = 0; i < 16; i++) m_reg[i] = 0;
    e = '0;
  endtask
  task automatic model_step(output exp_t e);
    int opd, r, nxt, res, cy;
    if (!m_run) begin
      e.pa = 4'd0;
      m_ir = rom[0];
      m_pc = 0;
      m_run = 1;
    end else begin
      opd = int'(m_ir[3:0]);
      r = m_reg[opd];
      nxt = LoadPC ? (SelPC ? opd : r) : IncPC ? (m_pc + 1) % 16 : m_pc;
      e.pa = 4'(nxt);
      case (SelALU)
        4'd1: begin res = (m_acc + r) % 16; cy = (m_acc + r > 15) ? 1 : 0; end
        4'd2: begin res = (m_acc - r + 16) % 16; cy = (r > m_acc) ? 1 : 0; end
        4'd3: begin res = 15 - (m_acc | r); cy = 0; end
        4'd12: begin res = m_acc / 2; cy = m_acc % 2; end
        4'd11: begin res = (m_acc * 2) % 16; cy = m_acc / 8; end
        default: begin res = m_acc; cy = 0; end
      endcase
      if (LoadReg) m_reg[opd] = m_acc;
      if (LoadAcc) begin
        case (SelAcc)
          2'd0: m_acc = opd;
          2'd1: begin m_acc = res; m_c = cy; end
          2'd2: m_acc = r;
          default: ;
        endcase
      end
      if (LoadIR) m_ir = rom[nxt];
      m_pc = nxt;
    end
    e.op = m_ir[7:4];
    e.z = m_acc != 0;
    e.c = m_c[0];
    e.h = m_run && m_ir[7:4] == 4'hF;
  endtask
  task automatic step(input logic li, ip, sp, lp, lr, la, input logic [1:0] sa,
                      input logic [3:0] alu, input bit rst);
    exp_t e;
    @(negedge CLK);
    cyc++;
    if (rnd_mode && $urandom_range(7) == 0) rom[$urandom_range(15)] = 8'($urandom);
    LoadIR = li; IncPC = ip; SelPC = sp; LoadPC = lp;
    LoadReg = lr; LoadAcc = la; SelAcc = sa; SelALU = alu;
    if (rst) begin
      #2 CLB = 1'b0;
      model_reset(e);
    end else begin
      CLB = 1'b1;
      #1 model_step(e);
    end
    q.push_back(e);
  endtask
  task automatic ctrl_step();
    logic [3:0] op;
    logic lp, sp, lr, la;
    logic [1:0] sa;
    op = m_ir[7:4];
    lp = 0; sp = 0; lr = 0; la = 0; sa = 2'b11;
    case (op)
      4'h1, 4'h2, 4'h3, 4'hB, 4'hC: begin la = 1; sa = 2'b01; end
      4'h4: begin la = 1; sa = 2'b10; end
      4'h5: lr = 1;
      4'hD: begin la = 1; sa = 2'b00; end
      4'h6: lp = m_acc == 0;
      4'h7: begin lp = m_acc == 0; sp = 1; end
      4'h8: lp = m_c[0];
      4'hA: begin lp = m_c[0]; sp = 1; end
      default: ;
    endcase
    if (op == 4'hF) step(0, 0, 0, 0, 0, 0, 2'b11, 4'h0, 0);
    else step(1, 1, sp, lp, lr, la, sa, op, 0);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("PCAddr", PCAddr, e.pa);
        @(posedge CLK);
        #1;
        chk("Opcode", Opcode, e.op);
        chk("Z", {3'b0, Z}, {3'b0, e.z});
        chk("C", {3'b0, C}, {3'b0, e.c});
        chk("Halted", {3'b0, Halted}, {3'b0, e.h});
      end
    end
  end
  initial begin
    rom = '{8'hD9, 8'h53, 8'h13, 8'h33, 8'hD5, 8'h51, 8'hD3, 8'h21,
            8'hD5, 8'h21, 8'hD9, 8'hB0, 8'hD9, 8'hC0, 8'h00, 8'hF0};
    step('x, 'x, 'x, 'x, 'x, 'x, 'x, 'x, 1);
    step('x, 'x, 'x, 'x, 'x, 'x, 'x, 'x, 1);
    step('x, 'x, 'x, 'x, 'x, 'x, 'x, 'x, 0);
    repeat (15 + 12) ctrl_step();
    rom = '{8'hD7, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0};
    step(0, 0, 0, 0, 0, 0, 2'b11, 4'h0, 1);
    step(0, 0, 0, 0, 0, 0, 2'b11, 4'h0, 0);
    repeat (5) ctrl_step();
    step(1, 1, 0, 0, 0, 1, 2'b00, 4'h0, 1);
    step(1, 1, 0, 0, 0, 1, 2'b00, 4'h0, 0);
    step(0, 0, 1, 1, 0, 0, 2'b11, 4'h0, 0);
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    rnd_mode = 1;
    for (int i = 0; i < 800; i++) begin
      logic [3:0] alu;
      case ($urandom_range(6))
        0: alu = 4'h1;
        1: alu = 4'h2;
        2: alu = 4'h3;
        3: alu = 4'hB;
        4: alu = 4'hC;
        default: alu = 4'($urandom);
      endcase
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(3) == 0),
           1'($urandom), 1'($urandom), 2'($urandom), alu, $urandom_range(59) == 0);
    end
    @(negedge CLK);
    #2;
    chk("queue drained", 4'(q.size()), 4'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
